// File: rtl/core_rvfi_sched_if.sv
// core_rvfi_sched_if
//   Bundle of the retirement push, completion and trace output signals of the
//   RVFI retirement scheduler.
//   master : pipeline/trace side (drives r_*/c_* inputs, observes r_ready/r_tag/t_*)
//   slave  : the scheduler itself
//   Parameters: XLEN datapath width, PW opaque packet width, DEPTH queue entries.
interface core_rvfi_sched_if #(
  parameter int XLEN  = 64,
  parameter int PW    = 128,
  parameter int DEPTH = 4
);
  localparam int TW = $clog2(DEPTH);

  // retirement push
  logic            r_valid;
  logic            r_ready;
  logic [TW-1:0]   r_tag;
  logic [PW-1:0]   r_info;
  logic [4:0]      r_rd_addr;
  logic [XLEN-1:0] r_rd_wdata;
  logic            r_pend;

  // late completion
  logic            c_valid;
  logic [TW-1:0]   c_tag;
  logic [XLEN-1:0] c_rd_wdata;
  logic [XLEN-1:0] c_mem_rdata;

  // trace output
  logic            t_valid;
  logic [63:0]     t_order;
  logic [PW-1:0]   t_info;
  logic [4:0]      t_rd_addr;
  logic [XLEN-1:0] t_rd_wdata;
  logic [XLEN-1:0] t_mem_rdata;
  logic            t_err;

  modport master (
    output r_valid, r_info, r_rd_addr, r_rd_wdata, r_pend,
    output c_valid, c_tag, c_rd_wdata, c_mem_rdata,
    input  r_ready, r_tag,
    input  t_valid, t_order, t_info, t_rd_addr, t_rd_wdata, t_mem_rdata, t_err
  );

  modport slave (
    input  r_valid, r_info, r_rd_addr, r_rd_wdata, r_pend,
    input  c_valid, c_tag, c_rd_wdata, c_mem_rdata,
    output r_ready, r_tag,
    output t_valid, t_order, t_info, t_rd_addr, t_rd_wdata, t_mem_rdata, t_err
  );
endinterface

// File: rtl/core_rvfi_sched.sv
// core_rvfi_sched
//   In-order retirement scheduler for the RVFI trace port. Retirement packets
//   are queued in program order; packets waiting on a late rd/load result stay
//   in the queue until a tagged completion supplies the data. Packets leave
//   strictly in order, at most one per cycle, stamped with a 64-bit order number.
//   Ports:
//     g_clk      clock, all state on rising edge
//     g_reset    asynchronous active-high reset
//     bus        core_rvfi_sched_if.slave (push r_*, completion c_*, trace t_*)
//   Parameters: XLEN, PW, DEPTH (power of 2, >= 2), ORDER_INIT (order counter
//   value after reset, normally 0).
module core_rvfi_sched #(
  parameter int          XLEN       = 64,
  parameter int          PW         = 128,
  parameter int          DEPTH      = 4,
  parameter logic [63:0] ORDER_INIT = 64'd0
) (
  input  logic             g_clk,
  input  logic             g_reset,
  core_rvfi_sched_if.slave bus
);

  localparam int TW   = $clog2(DEPTH);
  localparam int PTRW = TW + 1;

  // queue storage
  logic [PW-1:0]   info_q     [DEPTH];
  logic [4:0]      rd_addr_q  [DEPTH];
  logic [XLEN-1:0] rd_wdata_q [DEPTH];
  logic [XLEN-1:0] mem_rdata_q[DEPTH];
  logic [DEPTH-1:0] occ_q;
  logic [DEPTH-1:0] pend_q;

  logic [PTRW-1:0] head_q, tail_q;
  logic [63:0]     order_q;

  // output registers
  logic            t_valid_q;
  logic [63:0]     t_order_q;
  logic [PW-1:0]   t_info_q;
  logic [4:0]      t_rd_addr_q;
  logic [XLEN-1:0] t_rd_wdata_q;
  logic [XLEN-1:0] t_mem_rdata_q;
  logic            t_err_q;

  logic [TW-1:0]   head_idx, tail_idx;
  logic            empty, full;
  logic            push, c_ok, head_done, bypass, pop_q, pop, err_set;
  logic [PW-1:0]   e_info;
  logic [4:0]      e_rd_addr;
  logic [XLEN-1:0] e_rd_wdata, e_mem_rdata;

  always_comb begin
    head_idx = head_q[TW-1:0];
    tail_idx = tail_q[TW-1:0];
    empty    = (head_q == tail_q);
    full     = (head_idx == tail_idx) && (head_q[TW] != tail_q[TW]);

    push      = bus.r_valid && !full;
    // only an occupied, still-pending entry may be completed
    c_ok      = bus.c_valid && occ_q[bus.c_tag] && pend_q[bus.c_tag];
    head_done = c_ok && (bus.c_tag == head_idx);
    // a ready packet arriving at an empty queue leaves in the same cycle
    bypass    = empty && push && !bus.r_pend;
    pop_q     = !empty && occ_q[head_idx] && (!pend_q[head_idx] || head_done);
    pop       = bypass || pop_q;
    err_set   = (bus.r_valid && full) || (bus.c_valid && !c_ok);

    e_info      = info_q[head_idx];
    e_rd_addr   = rd_addr_q[head_idx];
    e_rd_wdata  = rd_wdata_q[head_idx];
    e_mem_rdata = mem_rdata_q[head_idx];
    if (bypass) begin
      e_info      = bus.r_info;
      e_rd_addr   = bus.r_rd_addr;
      e_rd_wdata  = bus.r_rd_wdata;
      e_mem_rdata = '0;
    end else if (head_done) begin
      e_rd_wdata  = bus.c_rd_wdata;
      e_mem_rdata = bus.c_mem_rdata;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        info_q[i]      <= '0;
        rd_addr_q[i]   <= '0;
        rd_wdata_q[i]  <= '0;
        mem_rdata_q[i] <= '0;
      end
      occ_q         <= '0;
      pend_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      order_q       <= ORDER_INIT;
      t_valid_q     <= 1'b0;
      t_order_q     <= '0;
      t_info_q      <= '0;
      t_rd_addr_q   <= '0;
      t_rd_wdata_q  <= '0;
      t_mem_rdata_q <= '0;
      t_err_q       <= 1'b0;
    end else begin
      t_valid_q <= pop;

      if (pop) begin
        t_order_q     <= order_q;
        order_q       <= order_q + 64'd1;
        t_info_q      <= e_info;
        t_rd_addr_q   <= e_rd_addr;
        t_rd_wdata_q  <= (e_rd_addr == 5'd0) ? '0 : e_rd_wdata;
        t_mem_rdata_q <= e_mem_rdata;
        head_q        <= head_q + PTRW'(1);
      end

      if (push) begin
        tail_q <= tail_q + PTRW'(1);
        // a bypassed packet never becomes a resident entry
        if (!bypass) begin
          info_q[tail_idx]      <= bus.r_info;
          rd_addr_q[tail_idx]   <= bus.r_rd_addr;
          rd_wdata_q[tail_idx]  <= bus.r_rd_wdata;
          mem_rdata_q[tail_idx] <= '0;
          pend_q[tail_idx]      <= bus.r_pend;
          occ_q[tail_idx]       <= 1'b1;
        end
      end

      // c_ok targets an occupied slot, so it never collides with the push slot
      if (c_ok) begin
        rd_wdata_q[bus.c_tag]  <= bus.c_rd_wdata;
        mem_rdata_q[bus.c_tag] <= bus.c_mem_rdata;
        pend_q[bus.c_tag]      <= 1'b0;
      end

      if (pop_q) begin
        occ_q[head_idx] <= 1'b0;
      end

      if (err_set) begin
        t_err_q <= 1'b1;
      end
    end
  end

  assign bus.r_ready     = !full;
  assign bus.r_tag       = tail_idx;
  assign bus.t_valid     = t_valid_q;
  assign bus.t_order     = t_order_q;
  assign bus.t_info      = t_info_q;
  assign bus.t_rd_addr   = t_rd_addr_q;
  assign bus.t_rd_wdata  = t_rd_wdata_q;
  assign bus.t_mem_rdata = t_mem_rdata_q;
  assign bus.t_err       = t_err_q;

endmodule

// File: tb/tb_core_rvfi_sched.sv
// tb_core_rvfi_sched
//   Directed bench for core_rvfi_sched: a table of per-cycle vectors with
//   hand-computed expectations, plus hand-written sequences for the full queue,
//   order-number wrap and asynchronous reset.
module tb_core_rvfi_sched;

  localparam int XLEN  = 64;
  localparam int PW    = 128;
  localparam int DEPTH = 4;

  logic g_clk;
  logic g_reset;
  int   n_chk;
  int   n_err;

  core_rvfi_sched_if #(.XLEN(XLEN), .PW(PW), .DEPTH(DEPTH)) bus  ();
  core_rvfi_sched_if #(.XLEN(XLEN), .PW(PW), .DEPTH(DEPTH)) bus2 ();

  core_rvfi_sched #(.XLEN(XLEN), .PW(PW), .DEPTH(DEPTH)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus)
  );

  // second instance with the order counter preset to 2^64-1 to reach the wrap
  core_rvfi_sched #(.XLEN(XLEN), .PW(PW), .DEPTH(DEPTH), .ORDER_INIT(64'hFFFF_FFFF_FFFF_FFFF)) dut_wrap (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .bus     (bus2)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    bit          rst;
    bit          rv;
    bit          rp;
    logic [4:0]  ra;
    logic [63:0] rw;
    logic [15:0] inf;
    bit          cv;
    logic [1:0]  ct;
    logic [63:0] crd;
    logic [63:0] cmem;
    bit          etv;
    logic [63:0] eord;
    logic [63:0] erd;
    logic [63:0] emem;
    logic [15:0] einf;
    bit          erdy;
    logic [1:0]  etag;
    bit          eerr;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  function automatic vec_t vin(bit rst, bit rv, bit rp, logic [4:0] ra, logic [63:0] rw,
                               logic [15:0] inf, bit cv, logic [1:0] ct,
                               logic [63:0] crd, logic [63:0] cmem);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rp = rp; v.ra = ra; v.rw = rw; v.inf = inf;
    v.cv = cv; v.ct = ct; v.crd = crd; v.cmem = cmem;
    v.etv = 1'b0; v.eord = 64'd0; v.erd = 64'd0; v.emem = 64'd0; v.einf = 16'd0;
    v.erdy = 1'b1; v.etag = 2'd0; v.eerr = 1'b0;
    return v;
  endfunction

  function automatic vec_t R();
    return vin(1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 1'b0, 2'd0, 64'd0, 64'd0);
  endfunction

  function automatic vec_t I();
    return vin(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 1'b0, 2'd0, 64'd0, 64'd0);
  endfunction

  function automatic vec_t P(logic [4:0] ra, logic [63:0] rw, logic [15:0] inf, bit rp);
    return vin(1'b0, 1'b1, rp, ra, rw, inf, 1'b0, 2'd0, 64'd0, 64'd0);
  endfunction

  function automatic vec_t C(logic [1:0] ct, logic [63:0] crd, logic [63:0] cmem);
    return vin(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 1'b1, ct, crd, cmem);
  endfunction

  function automatic vec_t E(vec_t v, bit etv, logic [63:0] eord, logic [63:0] erd,
                             logic [63:0] emem, logic [15:0] einf, logic [1:0] etag, bit eerr);
    vec_t r;
    r = v;
    r.etv = etv; r.eord = eord; r.erd = erd; r.emem = emem; r.einf = einf;
    r.erdy = 1'b1; r.etag = etag; r.eerr = eerr;
    return r;
  endfunction

  task automatic chk(string nm, int idx, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic set_in(bit rv, bit rp, logic [4:0] ra, logic [63:0] rw, logic [15:0] inf,
                        bit cv, logic [1:0] ct, logic [63:0] crd, logic [63:0] cmem);
    bus.r_valid     = rv;
    bus.r_pend      = rp;
    bus.r_rd_addr   = ra;
    bus.r_rd_wdata  = rw;
    bus.r_info      = {112'd0, inf};
    bus.c_valid     = cv;
    bus.c_tag       = ct;
    bus.c_rd_wdata  = crd;
    bus.c_mem_rdata = cmem;
  endtask

  task automatic set_idle();
    set_in(1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 1'b0, 2'd0, 64'd0, 64'd0);
  endtask

  task automatic set2(bit rv, logic [63:0] rw);
    bus2.r_valid     = rv;
    bus2.r_pend      = 1'b0;
    bus2.r_rd_addr   = 5'd1;
    bus2.r_rd_wdata  = rw;
    bus2.r_info      = '0;
    bus2.c_valid     = 1'b0;
    bus2.c_tag       = '0;
    bus2.c_rd_wdata  = '0;
    bus2.c_mem_rdata = '0;
  endtask

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    g_reset = 1'b1;
    #2;
    g_reset = 1'b0;
    #1;
  endtask

  task automatic check_vec(vec_t v, int i);
    chk("t_valid", i, 128'(bus.t_valid), 128'(v.etv));
    chk("r_ready", i, 128'(bus.r_ready), 128'(v.erdy));
    chk("r_tag",   i, 128'(bus.r_tag),   128'(v.etag));
    chk("t_err",   i, 128'(bus.t_err),   128'(v.eerr));
    chk("t_order", i, 128'(bus.t_order), 128'(v.eord));
    chk("t_rd_wdata",  i, 128'(bus.t_rd_wdata),  128'(v.erd));
    chk("t_mem_rdata", i, 128'(bus.t_mem_rdata), 128'(v.emem));
    chk("t_info",  i, bus.t_info, {112'd0, v.einf});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    g_reset = 1'b1;
    set_idle();
    set2(1'b0, 64'd0);

    // three ready packets back to back, rd_addr 0 forces wdata to 0
    vecs[0]  = E(R(),                              1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd0, 1'b0);
    vecs[1]  = E(P(5'd1, 64'hA, 16'd1, 1'b0),      1'b1, 64'd0, 64'hA,    64'd0,    16'd1, 2'd1, 1'b0);
    vecs[2]  = E(P(5'd2, 64'hB, 16'd2, 1'b0),      1'b1, 64'd1, 64'hB,    64'd0,    16'd2, 2'd2, 1'b0);
    vecs[3]  = E(P(5'd0, 64'hC, 16'd3, 1'b0),      1'b1, 64'd2, 64'd0,    64'd0,    16'd3, 2'd3, 1'b0);
    vecs[4]  = E(I(),                              1'b0, 64'd2, 64'd0,    64'd0,    16'd3, 2'd3, 1'b0);
    // pending head blocks a younger ready packet until its completion
    vecs[5]  = E(R(),                              1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd0, 1'b0);
    vecs[6]  = E(P(5'd5, 64'h11, 16'd4, 1'b1),     1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd1, 1'b0);
    vecs[7]  = E(P(5'd6, 64'h22, 16'd5, 1'b0),     1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd2, 1'b0);
    vecs[8]  = E(I(),                              1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd2, 1'b0);
    vecs[9]  = E(I(),                              1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd2, 1'b0);
    vecs[10] = E(I(),                              1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd2, 1'b0);
    vecs[11] = E(C(2'd0, 64'h55, 64'h99),          1'b1, 64'd0, 64'h55,   64'h99,   16'd4, 2'd2, 1'b0);
    vecs[12] = E(I(),                              1'b1, 64'd1, 64'h22,   64'd0,    16'd5, 2'd2, 1'b0);
    vecs[13] = E(I(),                              1'b0, 64'd1, 64'h22,   64'd0,    16'd5, 2'd2, 1'b0);
    // completion to an empty slot
    vecs[14] = E(C(2'd2, 64'hDEAD, 64'hBEEF),      1'b0, 64'd1, 64'h22,   64'd0,    16'd5, 2'd2, 1'b1);
    // second completion to an already completed entry leaves its data alone
    vecs[15] = E(R(),                              1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd0, 1'b0);
    vecs[16] = E(P(5'd7, 64'h70, 16'd6, 1'b1),     1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd1, 1'b0);
    vecs[17] = E(P(5'd8, 64'h80, 16'd7, 1'b1),     1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd2, 1'b0);
    vecs[18] = E(C(2'd1, 64'h81, 64'h82),          1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd2, 1'b0);
    vecs[19] = E(C(2'd1, 64'hDEAD, 64'hBEEF),      1'b0, 64'd0, 64'd0,    64'd0,    16'd0, 2'd2, 1'b1);
    vecs[20] = E(C(2'd0, 64'h71, 64'h72),          1'b1, 64'd0, 64'h71,   64'h72,   16'd6, 2'd2, 1'b1);
    vecs[21] = E(I(),                              1'b1, 64'd1, 64'h81,   64'h82,   16'd7, 2'd2, 1'b1);
    vecs[22] = E(I(),                              1'b0, 64'd1, 64'h81,   64'h82,   16'd7, 2'd2, 1'b1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst) begin
        set_idle();
        g_reset = 1'b1;
        #2;
        check_vec(vecs[i], i);
        g_reset = 1'b0;
        #2;
      end else begin
        set_in(vecs[i].rv, vecs[i].rp, vecs[i].ra, vecs[i].rw, vecs[i].inf,
               vecs[i].cv, vecs[i].ct, vecs[i].crd, vecs[i].cmem);
        cyc();
        check_vec(vecs[i], i);
      end
    end

    // full queue: overflow dropped, reverse-order completions, in-order drain
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      set_in(1'b1, 1'b1, 5'(k + 1), 64'(16 + k), 16'(32 + k), 1'b0, 2'd0, 64'd0, 64'd0);
      cyc();
    end
    chk("full_ready", 0, 128'(bus.r_ready), 128'd0);
    chk("full_tv",    0, 128'(bus.t_valid), 128'd0);
    set_in(1'b1, 1'b0, 5'd9, 64'h99, 16'h99, 1'b0, 2'd0, 64'd0, 64'd0);
    cyc();
    chk("ovf_err",   0, 128'(bus.t_err),   128'd1);
    chk("ovf_ready", 0, 128'(bus.r_ready), 128'd0);
    chk("ovf_tag",   0, 128'(bus.r_tag),   128'd0);
    for (int k = DEPTH - 1; k >= 1; k--) begin
      set_in(1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 1'b1, 2'(k), 64'(256 + k), 64'(512 + k));
      cyc();
      chk("rev_tv", k, 128'(bus.t_valid), 128'd0);
    end
    set_in(1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 1'b1, 2'd0, 64'd256, 64'd512);
    cyc();
    chk("drain_tv",    0, 128'(bus.t_valid),    128'd1);
    chk("drain_order", 0, 128'(bus.t_order),    128'd0);
    chk("drain_rd",    0, 128'(bus.t_rd_wdata), 128'd256);
    chk("drain_mem",   0, 128'(bus.t_mem_rdata), 128'd512);
    chk("drain_ready", 0, 128'(bus.r_ready),    128'd1);
    set_idle();
    for (int k = 1; k < DEPTH; k++) begin
      cyc();
      chk("drain_tv",    k, 128'(bus.t_valid),     128'd1);
      chk("drain_order", k, 128'(bus.t_order),     128'(k));
      chk("drain_rd",    k, 128'(bus.t_rd_wdata),  128'(256 + k));
      chk("drain_mem",   k, 128'(bus.t_mem_rdata), 128'(512 + k));
      chk("drain_addr",  k, 128'(bus.t_rd_addr),   128'(k + 1));
      chk("drain_info",  k, bus.t_info,            128'(32 + k));
    end
    cyc();
    chk("drain_end_tv", 0, 128'(bus.t_valid), 128'd0);

    // order number wrap on the preset instance
    chk("wrap_rst_order", 0, 128'(bus2.t_order), 128'd0);
    set2(1'b1, 64'h5);
    cyc();
    chk("wrap_tv",    0, 128'(bus2.t_valid), 128'd1);
    chk("wrap_order", 0, 128'(bus2.t_order), 128'hFFFF_FFFF_FFFF_FFFF);
    set2(1'b1, 64'h6);
    cyc();
    chk("wrap_order", 1, 128'(bus2.t_order), 128'd0);
    chk("wrap_rd",    1, 128'(bus2.t_rd_wdata), 128'h6);
    set2(1'b1, 64'h7);
    cyc();
    chk("wrap_order", 2, 128'(bus2.t_order), 128'd1);
    set2(1'b0, 64'h0);
    cyc();
    chk("wrap_tv", 3, 128'(bus2.t_valid), 128'd0);

    // asynchronous reset with a pending head and two younger entries queued
    do_reset();
    set_in(1'b1, 1'b0, 5'd3, 64'h33, 16'h30, 1'b0, 2'd0, 64'd0, 64'd0);
    cyc();
    set_in(1'b1, 1'b0, 5'd4, 64'h44, 16'h31, 1'b0, 2'd0, 64'd0, 64'd0);
    cyc();
    chk("ar_pre_order", 0, 128'(bus.t_order), 128'd1);
    set_in(1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 1'b1, 2'd3, 64'd1, 64'd1);
    cyc();
    chk("ar_pre_err", 0, 128'(bus.t_err), 128'd1);
    set_in(1'b1, 1'b1, 5'd5, 64'h55, 16'h32, 1'b0, 2'd0, 64'd0, 64'd0);
    cyc();
    set_in(1'b1, 1'b0, 5'd6, 64'h66, 16'h33, 1'b0, 2'd0, 64'd0, 64'd0);
    cyc();
    set_in(1'b1, 1'b0, 5'd7, 64'h77, 16'h34, 1'b0, 2'd0, 64'd0, 64'd0);
    cyc();
    chk("ar_pre_tag", 0, 128'(bus.r_tag),   128'd1);
    chk("ar_pre_tv",  0, 128'(bus.t_valid), 128'd0);
    set_idle();
    #2;
    g_reset = 1'b1;
    #1;
    chk("ar_tv",    0, 128'(bus.t_valid),    128'd0);
    chk("ar_order", 0, 128'(bus.t_order),    128'd0);
    chk("ar_rd",    0, 128'(bus.t_rd_wdata), 128'd0);
    chk("ar_addr",  0, 128'(bus.t_rd_addr),  128'd0);
    chk("ar_info",  0, bus.t_info,           128'd0);
    chk("ar_err",   0, 128'(bus.t_err),      128'd0);
    chk("ar_ready", 0, 128'(bus.r_ready),    128'd1);
    chk("ar_tag",   0, 128'(bus.r_tag),      128'd0);
    #2;
    g_reset = 1'b0;
    set_in(1'b1, 1'b0, 5'd8, 64'h88, 16'h40, 1'b0, 2'd0, 64'd0, 64'd0);
    cyc();
    chk("ar_post_tv",    0, 128'(bus.t_valid),    128'd1);
    chk("ar_post_order", 0, 128'(bus.t_order),    128'd0);
    chk("ar_post_rd",    0, 128'(bus.t_rd_wdata), 128'h88);
    chk("ar_post_info",  0, bus.t_info,           128'h40);
    // the pre-reset pending entry is gone, so completing it is stray
    set_in(1'b0, 1'b0, 5'd0, 64'd0, 16'd0, 1'b1, 2'd2, 64'h123, 64'h456);
    cyc();
    chk("ar_stale_tv",  0, 128'(bus.t_valid), 128'd0);
    chk("ar_stale_err", 0, 128'(bus.t_err),   128'd1);
    set_idle();
    cyc();
    chk("ar_end_tv", 0, 128'(bus.t_valid), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
